prng_stream_gen: RTL

//  Parametrised pseudo-random number generator with a built-in tick prescaler, run-time

---
 rtl/prng_stream_gen_pkg.sv | 13 +
 rtl/prng_stream_gen_if.sv | 14 +
 rtl/prng_stream_gen_prescaler.sv | 29 ++
 rtl/prng_stream_gen.sv | 92 +++++++++
 4 files changed

// File: rtl/prng_stream_gen_pkg.sv
// Shared types and default constants for the PRNG stream generator.
// Width-dependent defaults are resized at the point of use.
package prng_pkg;

   typedef enum logic {PRNG_LCG = 1'b0, PRNG_LFSR = 1'b1} prng_mode_e;

   localparam int              PRNG_WIDTH = 12;
   localparam int              PRNG_MULT  = 232;
   localparam int              PRNG_INC   = 1;
   localparam logic [11:0]     PRNG_TAPS  = 12'hE08;
   localparam logic [11:0]     PRNG_SEED  = 12'd1;

endpackage

// File: rtl/prng_stream_gen_if.sv
// Output stream of the PRNG: one-entry valid/ready buffer plus sticky overrun flag.
interface prng_stream_if
   import prng_pkg::*;
#(
   parameter int WIDTH = PRNG_WIDTH
);
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic             overrun;

   modport master (output out_data, output out_valid, output overrun, input out_ready);
   modport slave  (input out_data, input out_valid, input overrun, output out_ready);
endinterface

// File: rtl/prng_stream_gen_prescaler.sv
// Tick prescaler: one tick every DIV_MAX enabled cycles; clr restarts the period.
module prng_prescaler #(
   parameter int DIV_MAX = 2**27
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);
   localparam int CW = $clog2(DIV_MAX + 1);

   logic [CW-1:0] count_q, count_d;
   logic          terminal;

   assign terminal = (count_q == CW'(DIV_MAX - 1));
   assign tick     = en & terminal;

   always_comb begin
      count_d = count_q;
      if (clr)           count_d = '0;
      else if (en)       count_d = terminal ? '0 : count_q + CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) count_q <= '0;
      else        count_q <= count_d;
   end
endmodule

// File: rtl/prng_stream_gen.sv
// Prescaled LCG / Galois-LFSR generator with seed reload and a one-entry
// valid/ready output buffer that flags (rather than hides) dropped ticks.
module prng_stream_gen
   import prng_pkg::*;
#(
   parameter int               WIDTH   = PRNG_WIDTH,
   parameter int               DIV_MAX = 2**27,
   parameter int               MULT    = PRNG_MULT,
   parameter int               INC     = PRNG_INC,
   parameter logic [WIDTH-1:0] TAPS    = WIDTH'(PRNG_TAPS),
   parameter logic [WIDTH-1:0] SEED    = WIDTH'(PRNG_SEED)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             mode,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed_val,
   prng_stream_if.master    strm
);
   // Only the low WIDTH bits of the multiplier/increment affect a mod 2**WIDTH result.
   localparam logic [WIDTH-1:0] MULT_W = WIDTH'(MULT);
   localparam logic [WIDTH-1:0] INC_W  = WIDTH'(INC);

   prng_mode_e       mode_e;
   logic             tick, accept;
   logic [WIDTH-1:0] nxt;
   logic [WIDTH-1:0] state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             ovr_q, ovr_d;

   assign mode_e = prng_mode_e'(mode);

   prng_prescaler #(.DIV_MAX(DIV_MAX)) u_presc (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .clr   (seed_load),
      .tick  (tick)
   );

   always_comb begin
      nxt = MULT_W * state_q + INC_W;
      if (mode_e == PRNG_LFSR) begin
         // An all-zero state would lock the LFSR, so restart from SEED instead.
         if (state_q == '0)   nxt = SEED;
         else if (state_q[0]) nxt = (state_q >> 1) ^ TAPS;
         else                 nxt = state_q >> 1;
      end
   end

   assign accept = tick & (~valid_q | strm.out_ready);

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      if (seed_load) begin
         state_d = (mode_e == PRNG_LFSR && seed_val == '0) ? SEED : seed_val;
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end else if (accept) begin
         state_d = nxt;
         data_d  = nxt;
         valid_d = 1'b1;
      end else if (tick) begin
         ovr_d   = 1'b1;
      end else if (valid_q && strm.out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SEED;
         data_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign strm.out_data  = data_q;
   assign strm.out_valid = valid_q;
   assign strm.overrun   = ovr_q;
endmodule
